// File: rtl/seq_player.sv
// Sequence player for the "show sequence" phase: walks ROM entries 0..nivel, lighting each for
// ON_TICKS cycles followed by an OFF_TICKS blank gap. Optional abort input: SEQ_PLAYER_ABORT_EN.
module seq_player #(
  parameter int SIZE      = 4,
  parameter int ON_TICKS  = 50,
  parameter int OFF_TICKS = 25,
  parameter int CNT_W     = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
`ifdef SEQ_PLAYER_ABORT_EN
  input  logic            abort,
`endif
  input  logic [SIZE-1:0] nivel,
  output logic [SIZE-1:0] address,
  input  logic [SIZE-1:0] saida_in,
  output logic [SIZE-1:0] leds,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [SIZE-1:0]   address_q, address_d;
  logic [SIZE-1:0]   nivel_q, nivel_d;
  logic [SIZE-1:0]   leds_q, leds_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              abort_req;

`ifdef SEQ_PLAYER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    address_d = address_q;
    nivel_d   = nivel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    leds_d    = (state_q == S_ON) ? saida_in : '0;

    unique case (state_q)
      S_IDLE: begin
        // The done cycle itself must not restart playback.
        if (start && !done_q) begin
          nivel_d   = nivel;
          address_d = '0;
          timer_d   = '0;
          busy_d    = 1'b1;
          state_d   = S_ON;
        end
      end
      S_ON: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          state_d = S_OFF;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          if (address_q == nivel_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            address_d = address_q + 1'b1;
            state_d   = S_ON;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort wins over any timer transition, but only while playing.
    if (abort_req && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      timer_d   = '0;
      address_d = '0;
      leds_d    = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      address_q <= '0;
      nivel_q   <= '0;
      leds_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      address_q <= address_d;
      nivel_q   <= nivel_d;
      leds_q    <= leds_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign address = address_q;
  assign leds    = leds_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player with ON_TICKS=4, OFF_TICKS=2 and a behavioural ROM.
module tb_seq_player;

  localparam int SIZE = 4;
  localparam int ONT  = 4;
  localparam int OFFT = 2;
  localparam int STEP = ONT + OFFT;

  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic [SIZE-1:0] nivel;
  logic [SIZE-1:0] address;
  logic [SIZE-1:0] saida_in;
  logic [SIZE-1:0] leds;
  logic            busy;
  logic            done;
`ifdef SEQ_PLAYER_ABORT_EN
  logic            abort;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  seq_player #(.SIZE(SIZE), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .CNT_W(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
`ifdef SEQ_PLAYER_ABORT_EN
    .abort    (abort),
`endif
    .nivel    (nivel),
    .address  (address),
    .saida_in (saida_in),
    .leds     (leds),
    .busy     (busy),
    .done     (done)
  );

  function automatic logic [SIZE-1:0] rom(input logic [SIZE-1:0] a);
    case (a)
      4'd0:    rom = 4'b0001;
      4'd1:    rom = 4'b1000;
      4'd2:    rom = 4'b0100;
      4'd5:    rom = 4'b1010;
      default: rom = 4'b0001 << (a % 4);
    endcase
  endfunction

  assign saida_in = rom(address);

  // Packed view {leds, busy, done, address}.
  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got leds=%b busy=%b done=%b addr=%0d, want leds=%b busy=%b done=%b addr=%0d",
               name, act[9:6], act[5], act[4], act[3:0], exp[9:6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  function automatic logic [9:0] outs();
    outs = {leds, busy, done, address};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic            st;
    logic [SIZE-1:0] nv;
    logic [SIZE-1:0] leds;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] addr;
  } vec_t;

  vec_t tbl[28];

  initial begin
    // Edge k: inputs applied before edge k, outputs checked after it.
    // 0-19: nivel=2 run with ignored starts at 3, 10, 19 (done cycle); 20-27: restart with nivel=0.
    tbl[0]  = '{1, 2, 4'b0000, 1, 0, 0};
    tbl[1]  = '{0, 2, 4'b0001, 1, 0, 0};
    tbl[2]  = '{0, 2, 4'b0001, 1, 0, 0};
    tbl[3]  = '{1, 7, 4'b0001, 1, 0, 0};
    tbl[4]  = '{0, 7, 4'b0001, 1, 0, 0};
    tbl[5]  = '{0, 7, 4'b0000, 1, 0, 0};
    tbl[6]  = '{0, 7, 4'b0000, 1, 0, 1};
    tbl[7]  = '{0, 7, 4'b1000, 1, 0, 1};
    tbl[8]  = '{0, 7, 4'b1000, 1, 0, 1};
    tbl[9]  = '{0, 7, 4'b1000, 1, 0, 1};
    tbl[10] = '{1, 7, 4'b1000, 1, 0, 1};
    tbl[11] = '{0, 7, 4'b0000, 1, 0, 1};
    tbl[12] = '{0, 7, 4'b0000, 1, 0, 2};
    tbl[13] = '{0, 7, 4'b0100, 1, 0, 2};
    tbl[14] = '{0, 7, 4'b0100, 1, 0, 2};
    tbl[15] = '{0, 7, 4'b0100, 1, 0, 2};
    tbl[16] = '{0, 7, 4'b0100, 1, 0, 2};
    tbl[17] = '{0, 7, 4'b0000, 1, 0, 2};
    tbl[18] = '{0, 7, 4'b0000, 0, 1, 2};
    tbl[19] = '{1, 7, 4'b0000, 0, 0, 2};
    tbl[20] = '{1, 0, 4'b0000, 1, 0, 0};
    tbl[21] = '{0, 0, 4'b0001, 1, 0, 0};
    tbl[22] = '{0, 0, 4'b0001, 1, 0, 0};
    tbl[23] = '{0, 0, 4'b0001, 1, 0, 0};
    tbl[24] = '{0, 0, 4'b0001, 1, 0, 0};
    tbl[25] = '{0, 0, 4'b0000, 1, 0, 0};
    tbl[26] = '{0, 0, 4'b0000, 0, 1, 0};
    tbl[27] = '{0, 0, 4'b0000, 0, 0, 0};

    reset = 1'b1;
    start = 1'b0;
    nivel = '0;
`ifdef SEQ_PLAYER_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    check("reset_state", outs(), 10'b0);
    reset = 1'b0;
    tick();
    check("idle_after_reset", outs(), 10'b0);

    // Table-driven three-step run, ignored starts, restart and single step.
    for (int i = 0; i < 28; i++) begin
      start = tbl[i].st;
      nivel = tbl[i].nv;
      tick();
      check($sformatf("table_edge%0d", i), outs(),
            {tbl[i].leds, tbl[i].busy, tbl[i].done, tbl[i].addr});
    end
    start = 1'b0;
    tick();
    tick();

    // Full length nivel=15: address must reach 15 and never wrap.
    start = 1'b1;
    nivel = 4'd15;
    tick();
    start = 1'b0;
    check("full_edge0", outs(), {4'b0000, 1'b1, 1'b0, 4'd0});
    for (int k = 1; k <= 16 * STEP + 1; k++) begin
      logic [SIZE-1:0] ea, el;
      logic            eb, ed;
      int              stp;
      tick();
      stp = (k - 1) / STEP;
      ea  = (k / STEP > 15) ? 4'd15 : 4'(k / STEP);
      el  = (k <= 16 * STEP && ((k - 1) % STEP) < ONT) ? rom(4'(stp)) : 4'b0000;
      eb  = (k < 16 * STEP);
      ed  = (k == 16 * STEP);
      check($sformatf("full_edge%0d", k), outs(), {el, eb, ed, ea});
    end

    // Reset mid-ON of step 1 with nivel=3: immediate clear, no later done.
    start = 1'b1;
    nivel = 4'd3;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("pre_reset_step1_on", outs(), {4'b1000, 1'b1, 1'b0, 4'd1});
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_mid_on", outs(), 10'b0);
    tick();
    reset = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (done || busy || leds != 0) seen++;
      end
      check("quiet_after_reset", {6'b0, 4'(seen)}, 10'b0);
    end

`ifdef SEQ_PLAYER_ABORT_EN
    // Abort sampled at edge 9 of a nivel=2 run.
    start = 1'b1;
    nivel = 4'd2;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("pre_abort", outs(), {4'b1000, 1'b1, 1'b0, 4'd1});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_to_idle", outs(), 10'b0);
    begin
      int seen = 0;
      for (int k = 0; k < 30; k++) begin
        tick();
        if (done || busy) seen++;
      end
      check("no_done_after_abort", {6'b0, 4'(seen)}, 10'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
